shift_reg_univ: RTL and testbench

Parametrised universal shift register: the next-generation storage element after the single-bit gated D latch and edge-triggered flip-flops. A WIDTH-bit register built on rising-edge flip-flops supports hold, parallel load, logical/arithmetic shifts, rotates and clear. A saturating shift counter flags when a full word has been serialised. It is the parallel/serial conversion stage for later lab datapaths (serial transmitters, multipliers, LFSR seeds).

---
 rtl/shift_reg_univ.sv | 101 ++++++++++
 tb/tb_shift_reg_univ.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register: hold, load, shifts, rotates, clear, plus a saturating shift counter.
// Optional SHIFT_REG_UNIV_PARITY_EN builds an XOR tree driving Parity; otherwise Parity is tied low.
module shift_reg_univ #(
  parameter int WIDTH = 8
) (
  input  logic                         Clk,
  input  logic                         Resetn,
  input  logic                         En,
  input  logic [2:0]                   Mode,
  input  logic [WIDTH-1:0]             D,
  input  logic                         SerInL,
  input  logic                         SerInR,
  output logic [WIDTH-1:0]             Q,
  output logic                         SerOutL,
  output logic                         SerOutR,
  output logic [$clog2(WIDTH+1)-1:0]   ShiftCnt,
  output logic                         Done,
  output logic                         Parity
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_LSR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_ASR   = 3'b111;

  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic             counted;

  // No handshake: Mode/D are sampled on every rising edge where En=1, back-to-back ops allowed.
  always_comb begin
    q_next   = Q;
    cnt_next = ShiftCnt;
    counted  = 1'b0;
    case (Mode)
      MODE_HOLD: ;
      MODE_LOAD: begin
        q_next   = D;
        cnt_next = '0;
      end
      MODE_SHL: begin
        q_next  = {Q[WIDTH-2:0], SerInR};
        counted = 1'b1;
      end
      MODE_LSR: begin
        q_next  = {SerInL, Q[WIDTH-1:1]};
        counted = 1'b1;
      end
      MODE_ROL: begin
        q_next  = {Q[WIDTH-2:0], Q[WIDTH-1]};
        counted = 1'b1;
      end
      MODE_ROR: begin
        q_next  = {Q[0], Q[WIDTH-1:1]};
        counted = 1'b1;
      end
      MODE_CLEAR: begin
        q_next   = '0;
        cnt_next = '0;
      end
      MODE_ASR: begin
        q_next  = {Q[WIDTH-1], Q[WIDTH-1:1]};
        counted = 1'b1;
      end
      default: ;
    endcase
    // Counter saturates at WIDTH so Done stays up while shifting continues.
    if (counted && (ShiftCnt != CNT_FULL)) begin
      cnt_next = ShiftCnt + CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      Q        <= '0;
      ShiftCnt <= '0;
      Done     <= 1'b0;
    end else if (En) begin
      Q        <= q_next;
      ShiftCnt <= cnt_next;
      Done     <= (cnt_next == CNT_FULL);
    end
  end

  assign SerOutL = Q[WIDTH-1];
  assign SerOutR = Q[0];

`ifdef SHIFT_REG_UNIV_PARITY_EN
  assign Parity = ^Q;
`else
  assign Parity = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ (WIDTH=8): directed vector table from the test plan, then random ops
// checked against an independent behavioural model, all through an expected-value queue.
module tb_shift_reg_univ;

  localparam int WIDTH = 8;
  localparam int CW    = 4;
  localparam int SBW   = WIDTH + CW + 1;

  logic             Clk;
  logic             Resetn;
  logic             En;
  logic [2:0]       Mode;
  logic [WIDTH-1:0] D;
  logic             SerInL;
  logic             SerInR;
  logic [WIDTH-1:0] Q;
  logic             SerOutL;
  logic             SerOutR;
  logic [CW-1:0]    ShiftCnt;
  logic             Done;
  logic             Parity;

  shift_reg_univ #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Resetn   (Resetn),
    .En       (En),
    .Mode     (Mode),
    .D        (D),
    .SerInL   (SerInL),
    .SerInR   (SerInR),
    .Q        (Q),
    .SerOutL  (SerOutL),
    .SerOutR  (SerOutR),
    .ShiftCnt (ShiftCnt),
    .Done     (Done),
    .Parity   (Parity)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic             resetn;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sl;
    logic             sr;
    logic [WIDTH-1:0] exp_q;
    logic [CW-1:0]    exp_cnt;
    logic             exp_done;
  } vec_t;

  vec_t vecs[$];

  logic [SBW-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    m_cnt;

  task automatic add_vec(input logic rn, input logic en, input logic [2:0] mode,
                         input logic [WIDTH-1:0] d, input logic sl, input logic sr,
                         input logic [WIDTH-1:0] eq, input logic [CW-1:0] ec, input logic ed);
    vec_t v;
    v.resetn = rn; v.en = en; v.mode = mode; v.d = d; v.sl = sl; v.sr = sr;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic check_bit(input string name, input int idx, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, req);
    end
  endtask

  // scoreboard: pop one expected record and compare all outputs
  task automatic compare_out(input int idx);
    logic [SBW-1:0]   rec;
    logic [WIDTH-1:0] eq;
    logic [CW-1:0]    ec;
    logic             ed;
    logic             ep;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty step %0d", idx);
      return;
    end
    rec = exp_q.pop_front();
    {eq, ec, ed} = rec;
`ifdef SHIFT_REG_UNIV_PARITY_EN
    ep = ^eq;
`else
    ep = 1'b0;
`endif
    n_checks++;
    if (Q !== eq) begin
      n_fail++;
      $display("FAIL q step %0d: got %h expected %h", idx, Q, eq);
    end
    n_checks++;
    if (ShiftCnt !== ec) begin
      n_fail++;
      $display("FAIL shift_cnt step %0d: got %0d expected %0d", idx, ShiftCnt, ec);
    end
    check_bit("done", idx, Done, ed);
    check_bit("ser_out_l", idx, SerOutL, eq[WIDTH-1]);
    check_bit("ser_out_r", idx, SerOutR, eq[0]);
    check_bit("parity", idx, Parity, ep);
  endtask

  // driver: push expectation, drive inputs away from the edge, sample #1 after the edge
  task automatic drive_op(input int idx, input logic rn, input logic en, input logic [2:0] mode,
                          input logic [WIDTH-1:0] d, input logic sl, input logic sr,
                          input logic [WIDTH-1:0] eq, input logic [CW-1:0] ec, input logic ed);
    exp_q.push_back({eq, ec, ed});
    Resetn = rn; En = en; Mode = mode; D = d; SerInL = sl; SerInR = sr;
    @(posedge Clk);
    #1;
    compare_out(idx);
  endtask

  // independent behavioural reference for the random phase
  task automatic model_step(input logic rn, input logic en, input logic [2:0] mode,
                            input logic [WIDTH-1:0] d, input logic sl, input logic sr);
    logic [WIDTH-1:0] nq;
    int nc;
    nq = m_q;
    nc = int'(m_cnt);
    if (!rn) begin
      m_q = '0;
      m_cnt = '0;
      return;
    end
    if (!en) return;
    case (mode)
      3'd1: begin nq = d; nc = 0; end
      3'd2: begin nq = (m_q << 1) | {{(WIDTH-1){1'b0}}, sr}; nc = nc + 1; end
      3'd3: begin nq = (m_q >> 1) | ({{(WIDTH-1){1'b0}}, sl} << (WIDTH-1)); nc = nc + 1; end
      3'd4: begin nq = (m_q << 1) | (m_q >> (WIDTH-1)); nc = nc + 1; end
      3'd5: begin nq = (m_q >> 1) | (m_q << (WIDTH-1)); nc = nc + 1; end
      3'd6: begin nq = '0; nc = 0; end
      3'd7: begin nq = $signed(m_q) >>> 1; nc = nc + 1; end
      default: ;
    endcase
    if (nc > WIDTH) nc = WIDTH;
    m_q = nq;
    m_cnt = CW'(nc);
  endtask

  initial begin
    vec_t v;
    logic rn, en, sl, sr;
    logic [2:0] mode;
    logic [WIDTH-1:0] d;

    n_checks = 0;
    n_fail = 0;
    Resetn = 1'b0; En = 1'b0; Mode = 3'd0; D = '0; SerInL = 1'b0; SerInR = 1'b0;

    // reset overrides En/Mode/D
    add_vec(0, 1, 3'd1, 8'hFF, 0, 0, 8'h00, 4'd0, 0);
    // serialise 0xA5 with SerInR=1
    add_vec(1, 1, 3'd1, 8'hA5, 0, 0, 8'hA5, 4'd0, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 1, 8'h4B, 4'd1, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 1, 8'h97, 4'd2, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 1, 8'h2F, 4'd3, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 1, 8'h5F, 4'd4, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 1, 8'hBF, 4'd5, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 1, 8'h7F, 4'd6, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 1, 8'hFF, 4'd7, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 1, 8'hFF, 4'd8, 1);
    // rotate right and saturate
    add_vec(1, 1, 3'd1, 8'h81, 0, 0, 8'h81, 4'd0, 0);
    add_vec(1, 1, 3'd5, 8'h00, 1, 1, 8'hC0, 4'd1, 0);
    add_vec(1, 1, 3'd5, 8'h00, 1, 1, 8'h60, 4'd2, 0);
    add_vec(1, 1, 3'd5, 8'h00, 1, 1, 8'h30, 4'd3, 0);
    add_vec(1, 1, 3'd5, 8'h00, 1, 1, 8'h18, 4'd4, 0);
    add_vec(1, 1, 3'd5, 8'h00, 1, 1, 8'h0C, 4'd5, 0);
    add_vec(1, 1, 3'd5, 8'h00, 1, 1, 8'h06, 4'd6, 0);
    add_vec(1, 1, 3'd5, 8'h00, 1, 1, 8'h03, 4'd7, 0);
    add_vec(1, 1, 3'd5, 8'h00, 1, 1, 8'h81, 4'd8, 1);
    add_vec(1, 1, 3'd5, 8'h00, 1, 1, 8'hC0, 4'd8, 1);
    add_vec(1, 1, 3'd5, 8'h00, 1, 1, 8'h60, 4'd8, 1);
    // hold keeps count and Done; load drops Done
    add_vec(1, 1, 3'd0, 8'h33, 1, 1, 8'h60, 4'd8, 1);
    add_vec(1, 1, 3'd1, 8'h07, 0, 0, 8'h07, 4'd0, 0);
    add_vec(1, 1, 3'd1, 8'h03, 0, 0, 8'h03, 4'd0, 0);
    // arithmetic vs logical right shift
    add_vec(1, 1, 3'd1, 8'h90, 0, 0, 8'h90, 4'd0, 0);
    add_vec(1, 1, 3'd7, 8'h00, 0, 0, 8'hC8, 4'd1, 0);
    add_vec(1, 1, 3'd7, 8'h00, 0, 0, 8'hE4, 4'd2, 0);
    add_vec(1, 1, 3'd1, 8'h90, 0, 0, 8'h90, 4'd0, 0);
    add_vec(1, 1, 3'd3, 8'h00, 0, 1, 8'h48, 4'd1, 0);
    add_vec(1, 1, 3'd3, 8'h00, 1, 0, 8'hA4, 4'd2, 0);
    // rotate left, shift left with SerInR=0, clear
    add_vec(1, 1, 3'd1, 8'h81, 0, 0, 8'h81, 4'd0, 0);
    add_vec(1, 1, 3'd4, 8'h00, 0, 0, 8'h03, 4'd1, 0);
    add_vec(1, 1, 3'd2, 8'h00, 1, 0, 8'h06, 4'd2, 0);
    add_vec(1, 1, 3'd6, 8'hFF, 1, 1, 8'h00, 4'd0, 0);
    // enable gating, then reset with ShiftCnt=5
    add_vec(1, 1, 3'd1, 8'h5A, 0, 0, 8'h5A, 4'd0, 0);
    add_vec(1, 0, 3'd1, 8'h3C, 1, 1, 8'h5A, 4'd0, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 0, 8'hB4, 4'd1, 0);
    add_vec(1, 0, 3'd2, 8'h00, 0, 1, 8'hB4, 4'd1, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 0, 8'h68, 4'd2, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 0, 8'hD0, 4'd3, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 0, 8'hA0, 4'd4, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 0, 8'h40, 4'd5, 0);
    add_vec(0, 1, 3'd2, 8'h00, 0, 1, 8'h00, 4'd0, 0);
    add_vec(1, 1, 3'd2, 8'h00, 0, 1, 8'h01, 4'd1, 0);

    repeat (2) @(posedge Clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive_op(i, v.resetn, v.en, v.mode, v.d, v.sl, v.sr, v.exp_q, v.exp_cnt, v.exp_done);
    end

    // random phase: model starts from the last directed expectation
    m_q = 8'h01;
    m_cnt = 4'd1;
    for (int i = 0; i < 400; i++) begin
      rn   = ($urandom_range(0, 31) != 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = 3'($urandom_range(0, 7));
      if (mode == 3'd1 && $urandom_range(0, 2) != 0) mode = 3'($urandom_range(2, 5));
      d    = WIDTH'($urandom_range(0, 255));
      sl   = 1'($urandom_range(0, 1));
      sr   = 1'($urandom_range(0, 1));
      model_step(rn, en, mode, d, sl, sr);
      drive_op(1000 + i, rn, en, mode, d, sl, sr, m_q, m_cnt, (m_cnt == CW'(WIDTH)));
    end

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
